logic_clock_domain_crossing_gray_write: RTL and testbench
=========================================================

LOGIC_CLOCK_DOMAIN_CROSSING_GRAY_WRITE -- requirements
Module: logic_clock_domain_crossing_gray_write

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 1, meaning bits per data word.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 3, meaning memory address bits; DEPTH = 2**ADDRESS_WIDTH.
REQ-003 SHALL have parameter READY_THRESHOLD, default DEPTH-3, meaning fill level at or above which rx_tready deasserts.
REQ-004 SHALL have parameter WRITE_REGISTERED, default 0, meaning 1 adds one register stage on the memory write port.
REQ-005 SHALL have port rx_aclk, input, 1, the single clock; all logic SHALL be in this domain.
REQ-006 SHALL have port rx_areset, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port rx_tvalid, input, 1, Rx valid.
REQ-008 SHALL have port rx_tdata, input, DATA_WIDTH, Rx data.
REQ-009 SHALL have port rx_tready, output, 1, Rx ready, registered.
REQ-010 SHALL have port write_enable, output, 1, memory write strobe.
REQ-011 SHALL have port write_data, output, DATA_WIDTH, memory write data.
REQ-012 SHALL have port write_address, output, ADDRESS_WIDTH, memory write address.
REQ-013 SHALL have port write_pointer_gray, output, ADDRESS_WIDTH+1, Gray-coded write pointer for the read domain, registered.
REQ-014 SHALL have port read_pointer_gray_synced, input, ADDRESS_WIDTH+1, Gray read pointer already synchronised into rx_aclk.
REQ-015 SHALL have port fill_level, output, ADDRESS_WIDTH+1, registered occupancy estimate 0..DEPTH.
REQ-016 SHALL have port almost_full, output, 1, fill_level >= READY_THRESHOLD.

Function
REQ-017 SHALL fail elaboration unless ADDRESS_WIDTH >= 3, 1 <= READY_THRESHOLD <= DEPTH-2, WRITE_REGISTERED in {0,1}.
REQ-018 SHALL accept a word on every rising edge where rx_tvalid && rx_tready (accept).
REQ-019 SHALL hold an internal binary write pointer wp of ADDRESS_WIDTH+1 bits, incremented by 1 per accept, wrapping 2*DEPTH-1 -> 0.
REQ-020 SHALL convert read_pointer_gray_synced to binary rp combinationally (gray-to-binary, MSB-first XOR).
REQ-021 SHALL register fill_level <= wp - rp modulo 2**(ADDRESS_WIDTH+1) every cycle (one-cycle latency).
REQ-022 SHALL register rx_tready <= (fill_level < READY_THRESHOLD) every cycle, ignoring rx_tvalid.
REQ-023 WRITE_REGISTERED=0: write_enable = accept, write_data = rx_tdata, write_address = wp[ADDRESS_WIDTH-1:0], combinationally, same cycle.
REQ-024 WRITE_REGISTERED=1: write_enable, write_data, write_address SHALL be the REQ-023 values delayed one cycle; write_data SHALL only load on accept.
REQ-025 SHALL update write_pointer_gray to bin2gray(pointer after write) on the edge that completes the memory write: same edge as wp for mode 0, one edge later for mode 1; never ahead of the data.
REQ-026 write_pointer_gray SHALL change by exactly one bit per update, including wrap 2*DEPTH-1 -> 0.
REQ-027 True occupancy (wp - binary of read pointer at read side) SHALL never exceed DEPTH under any read timing; guaranteed by REQ-017 threshold bound (two-cycle ready lag).
REQ-028 A stale read pointer SHALL only overestimate fill_level; no underflow of fill_level SHALL occur.

Reset
REQ-029 On rx_areset high, immediately: wp=0, write_pointer_gray=0, fill_level=0, rx_tready=0, almost_full=0, registered write stage (mode 1) write_enable=0, write_address=0, write_data=0.
REQ-030 Reset mid-transfer SHALL discard in-flight accepts; the first edge after release SHALL set rx_tready=1 (fill_level=0 < threshold).
REQ-031 Reset is a block-wide event; the read side SHALL be reset concurrently (integration requirement, not checked here).

Verification
REQ-032 ADDRESS_WIDTH=3, threshold 5, read pointer held 0, rx_tvalid=1 constant -> exactly 7 accepts, rx_tready low from then on, fill_level settles 7, never 8+.
REQ-033 Same, then read_pointer_gray_synced steps to gray(4) -> fill_level 3 one cycle later, rx_tready high the cycle after.
REQ-034 Continuous stream with read pointer tracking wp-2 for 40 words -> write_pointer_gray sequence passes 15 -> 0 (gray 0b01000 -> 0b00000), one bit change per step, write_address wraps 7 -> 0.
REQ-035 WRITE_REGISTERED=1, single word 0xA5 accepted at edge N -> write_enable/write_data=0xA5/write_address=0 at cycle N+1, write_pointer_gray=1 after edge N+1, not before.
REQ-036 Assert rx_areset asynchronously between edges with fill_level=4 -> all outputs zero before next edge; after release rx_tready=1 on first edge, next accept writes address 0.
REQ-037 Random rx_tvalid and random legal read pointer advances, 10k cycles, scoreboard -> no overflow, data order preserved, fill_level within [true occupancy, true occupancy + in-flight lag].

Source files
------------

// File: rtl/logic_clock_domain_crossing_gray_write.sv
// Write side of a Gray-pointer asynchronous FIFO: accepts Rx words, drives the memory write port,
// publishes a Gray write pointer and throttles rx_tready from a registered fill estimate.
module logic_clock_domain_crossing_gray_write #(
    parameter int DATA_WIDTH       = 1,
    parameter int ADDRESS_WIDTH    = 3,
    parameter int READY_THRESHOLD  = (2 ** ADDRESS_WIDTH) - 3,
    parameter int WRITE_REGISTERED = 0
) (
    input  logic                     rx_aclk,
    input  logic                     rx_areset,
    input  logic                     rx_tvalid,
    input  logic [DATA_WIDTH-1:0]    rx_tdata,
    output logic                     rx_tready,
    output logic                     write_enable,
    output logic [DATA_WIDTH-1:0]    write_data,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic [ADDRESS_WIDTH:0]   write_pointer_gray,
    input  logic [ADDRESS_WIDTH:0]   read_pointer_gray_synced,
    output logic [ADDRESS_WIDTH:0]   fill_level,
    output logic                     almost_full
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int PW    = ADDRESS_WIDTH + 1;
    localparam logic [PW-1:0] THRESHOLD = PW'(READY_THRESHOLD);

    generate
        if (ADDRESS_WIDTH < 3 || READY_THRESHOLD < 1 || READY_THRESHOLD > DEPTH - 2 ||
            (WRITE_REGISTERED != 0 && WRITE_REGISTERED != 1)) begin : g_bad_parameters
            $error("logic_clock_domain_crossing_gray_write: illegal parameter combination");
        end
    endgenerate

    function automatic logic [PW-1:0] binary_to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray_to_binary(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic          accept;
    logic [PW-1:0] wp;
    logic [PW-1:0] wp_next;
    logic [PW-1:0] rp;

    assign accept      = rx_tvalid && rx_tready;
    assign wp_next     = wp + {{ADDRESS_WIDTH{1'b0}}, accept};
    assign rp          = gray_to_binary(read_pointer_gray_synced);
    assign almost_full = (fill_level >= THRESHOLD);

    // NOTE: fill_level uses a synchronised (older) read pointer, so it can only overestimate;
    // the threshold margin covers the two-cycle lag from fill_level to rx_tready.
    always_ff @(posedge rx_aclk or posedge rx_areset) begin
        if (rx_areset) begin
            wp         <= '0;
            fill_level <= '0;
            rx_tready  <= 1'b0;
        end else begin
            wp         <= wp_next;
            fill_level <= wp - rp;
            rx_tready  <= (fill_level < THRESHOLD);
        end
    end

    generate
        if (WRITE_REGISTERED == 0) begin : g_write_direct
            assign write_enable  = accept;
            assign write_data    = rx_tdata;
            assign write_address = wp[ADDRESS_WIDTH-1:0];

            always_ff @(posedge rx_aclk or posedge rx_areset) begin
                if (rx_areset) begin
                    write_pointer_gray <= '0;
                end else begin
                    write_pointer_gray <= binary_to_gray(wp_next);
                end
            end
        end else begin : g_write_registered
            logic                     write_enable_q;
            logic [DATA_WIDTH-1:0]    write_data_q;
            logic [ADDRESS_WIDTH-1:0] write_address_q;

            assign write_enable  = write_enable_q;
            assign write_data    = write_data_q;
            assign write_address = write_address_q;

            // Gray pointer follows wp one edge late, i.e. on the edge that lands the data.
            always_ff @(posedge rx_aclk or posedge rx_areset) begin
                if (rx_areset) begin
                    write_enable_q     <= 1'b0;
                    write_data_q       <= '0;
                    write_address_q    <= '0;
                    write_pointer_gray <= '0;
                end else begin
                    write_enable_q     <= accept;
                    write_address_q    <= wp[ADDRESS_WIDTH-1:0];
                    write_pointer_gray <= binary_to_gray(wp);
                    if (accept) begin
                        write_data_q <= rx_tdata;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_logic_clock_domain_crossing_gray_write.sv
// Directed and randomised checks of the Gray write side: dut0 direct write port, dut1 registered.
module tb_logic_clock_domain_crossing_gray_write;

    localparam int DW  = 8;
    localparam int AW  = 3;
    localparam int THR = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          v0, rdy0, we0, af0;
    logic [DW-1:0] d0, wd0;
    logic [AW-1:0] wa0;
    logic [AW:0]   wpg0, rp0g, fl0;

    logic          v1, rdy1, we1, af1;
    logic [DW-1:0] d1, wd1;
    logic [AW-1:0] wa1;
    logic [AW:0]   wpg1, rp1g, fl1;

    logic_clock_domain_crossing_gray_write #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WRITE_REGISTERED(0)
    ) u_dut0 (
        .rx_aclk(clk), .rx_areset(rst), .rx_tvalid(v0), .rx_tdata(d0), .rx_tready(rdy0),
        .write_enable(we0), .write_data(wd0), .write_address(wa0),
        .write_pointer_gray(wpg0), .read_pointer_gray_synced(rp0g),
        .fill_level(fl0), .almost_full(af0)
    );

    logic_clock_domain_crossing_gray_write #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .WRITE_REGISTERED(1)
    ) u_dut1 (
        .rx_aclk(clk), .rx_areset(rst), .rx_tvalid(v1), .rx_tdata(d1), .rx_tready(rdy1),
        .write_enable(we1), .write_data(wd1), .write_address(wa1),
        .write_pointer_gray(wpg1), .read_pointer_gray_synced(rp1g),
        .fill_level(fl1), .almost_full(af1)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] b2g(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Reference model of dut0 and a behavioural memory captured from its write port.
    logic [3:0]    m_wp, m_fill;
    logic          m_ready;
    logic          last_acc;
    logic [2:0]    last_addr;
    int            n_we;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mem[8];

    task automatic model_reset();
        m_wp = '0;
        m_fill = '0;
        m_ready = 1'b0;
        exp_q.delete();
    endtask

    // One clock for everything; checks dut0 against the model before and after the edge.
    task automatic step0();
        logic       acc;
        logic [3:0] nf;
        #1;
        acc = v0 && m_ready;
        check("we0", we0, acc);
        if (acc) begin
            check("wa0", wa0, m_wp[2:0]);
            check("wd0", wd0, d0);
            exp_q.push_back(d0);
        end
        if (we0) begin
            mem[wa0] = wd0;
            n_we++;
        end
        last_addr = wa0;
        nf = m_wp - g2b(rp0g);
        @(posedge clk);
        m_ready = (m_fill < THR);
        m_fill = nf;
        if (acc) m_wp = m_wp + 4'd1;
        last_acc = acc;
        #1;
        check("fill0", fl0, m_fill);
        check("rdy0", rdy0, m_ready);
        check("wpg0", wpg0, b2g(m_wp));
        check("af0", af0, m_fill >= THR);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         maxf, n, cyc;
        logic [3:0] prev_g, rd, s1, wr_vis, occ;
        logic [2:0] prev_a;
        logic       saw_gw, saw_aw;
        logic [DW-1:0] e;

        rst = 1'b1;
        v0 = 1'b0; d0 = '0; rp0g = '0;
        v1 = 1'b0; d1 = '0; rp1g = '0;
        model_reset();
        n_we = 0;

        // Reset state
        #3;
        check("rst_rdy0", rdy0, 0);
        check("rst_fill0", fl0, 0);
        check("rst_wpg0", wpg0, 0);
        check("rst_af0", af0, 0);
        check("rst_we0", we0, 0);
        check("rst_wa0", wa0, 0);
        check("rst_rdy1", rdy1, 0);
        check("rst_we1", we1, 0);
        check("rst_wa1", wa1, 0);
        check("rst_wd1", wd1, 0);
        check("rst_wpg1", wpg1, 0);
        check("rst_fill1", fl1, 0);

        // Fill with the read pointer held at 0: exactly 7 accepts, then stall at fill 7
        @(negedge clk);
        rst = 1'b0;
        v0 = 1'b1;
        maxf = 0;
        for (int i = 0; i < 15; i++) begin
            d0 = 8'(i + 16);
            step0();
            if (int'(fl0) > maxf) maxf = int'(fl0);
        end
        check("fill_accepts", n_we, 7);
        check("fill_max", maxf, 7);
        check("fill_settle", fl0, 7);
        check("fill_rdy_low", rdy0, 0);
        check("fill_af", af0, 1);
        check("fill_wpg", wpg0, 4'b0100);

        // Read pointer jumps to 4
        rp0g = 4'b0110;
        step0();
        check("rp4_fill", fl0, 3);
        check("rp4_rdy_lag", rdy0, 0);
        step0();
        check("rp4_rdy", rdy0, 1);
        check("rp4_af", af0, 0);
        v0 = 1'b0;

        // Continuous stream with reader trailing by two words, across the pointer wrap
        prev_g = wpg0;
        prev_a = 3'd6;
        saw_gw = 1'b0;
        saw_aw = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 40 && cyc < 200) begin
            v0 = 1'b1;
            d0 = 8'(n);
            rp0g = b2g(m_wp - 4'd2);
            step0();
            cyc++;
            if (last_acc) begin
                n++;
                check("gray_1bit", $countones(wpg0 ^ prev_g), 1);
                if (prev_g == 4'b1000 && wpg0 == 4'b0000) saw_gw = 1'b1;
                if (prev_a == 3'd7 && last_addr == 3'd0) saw_aw = 1'b1;
                prev_a = last_addr;
                prev_g = wpg0;
            end
        end
        v0 = 1'b0;
        check("stream_cnt", n, 40);
        check("stream_gray_wrap", saw_gw, 1);
        check("stream_addr_wrap", saw_aw, 1);

        // Asynchronous reset mid-cycle with fill_level 4
        rp0g = b2g(m_wp - 4'd4);
        step0();
        step0();
        check("pre_rst_fill", fl0, 4);
        #3;
        v0 = 1'b1;
        d0 = '0;
        rst = 1'b1;
        #1;
        check("arst_rdy0", rdy0, 0);
        check("arst_fill0", fl0, 0);
        check("arst_wpg0", wpg0, 0);
        check("arst_af0", af0, 0);
        check("arst_we0", we0, 0);
        check("arst_wa0", wa0, 0);
        check("arst_wd0", wd0, 0);
        #2;
        rst = 1'b0;
        rp0g = '0;
        model_reset();
        step0();
        check("rel_rdy0", rdy0, 1);
        d0 = 8'h3C;
        #2;
        check("rel_we0", we0, 1);
        check("rel_wa0", wa0, 0);
        step0();
        check("rel_wpg0", wpg0, 1);
        v0 = 1'b0;

        // Registered write port: data and Gray pointer one edge after the accept
        v1 = 1'b1;
        d1 = 8'hA5;
        #1;
        check("m1_pre_we", we1, 0);
        check("m1_pre_rdy", rdy1, 1);
        step0();
        v1 = 1'b0;
        d1 = 8'h5A;
        check("m1_we", we1, 1);
        check("m1_wd", wd1, 8'hA5);
        check("m1_wa", wa1, 0);
        check("m1_wpg_not_yet", wpg1, 0);
        step0();
        check("m1_wpg", wpg1, 1);
        check("m1_we_off", we1, 0);
        check("m1_wd_hold", wd1, 8'hA5);
        v1 = 1'b1;
        d1 = 8'h3C;
        step0();
        v1 = 1'b0;
        check("m1_we2", we1, 1);
        check("m1_wd2", wd1, 8'h3C);
        check("m1_wa2", wa1, 1);
        check("m1_wpg2_not_yet", wpg1, 1);
        step0();
        check("m1_wpg2", wpg1, 4'b0011);

        // Random writer against a reader with a two-stage pointer synchroniser
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        rp0g = '0;
        rd = '0;
        s1 = '0;
        for (int i = 0; i < 3000; i++) begin
            v0 = ($urandom_range(0, 3) != 0);
            d0 = 8'($urandom);
            step0();
            wr_vis = g2b(wpg0);
            occ = wr_vis - rd;
            check("occ_le_depth", occ <= 4'd8, 1);
            if ($urandom_range(0, 1) == 0 && rd != wr_vis) begin
                if (exp_q.size() == 0) begin
                    check("rd_queue_empty", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", mem[rd[2:0]], e);
                end
                rd = rd + 4'd1;
            end
            rp0g = s1;
            s1 = b2g(rd);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
